capture_scheduler: RTL and testbench
====================================

CAPTURE_SCHEDULER -- requirements
Module: capture_scheduler

Interface
REQ-001 Parameter BYTE_CNT_W, default 18: width of the per-frame byte counter.
REQ-002 Parameter ADAPT_HOLD, default 4: number of frames an escalated mode is held after an overflow.
REQ-003 pclk  in  1  camera pixel clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cam_vsync  in  1  camera frame-valid, the same signal the adapter sees.
REQ-006 adapter_write_en  in  1  adapter FIFO write strobe.
REQ-007 fifo_full  in  1  frame FIFO full flag.
REQ-008 cfg_we  in  1  schedule-slot write strobe.
REQ-009 cfg_addr  in  2  schedule slot index.
REQ-010 cfg_data  in  3  compress mode for the addressed slot.
REQ-011 cfg_len  in  2  last active slot (schedule length minus 1).
REQ-012 cfg_adaptive  in  1  enables overflow-driven mode escalation.
REQ-013 compress_command  out  3  mode presented to the adapter for the next frame.
REQ-014 slot_idx  out  2  schedule slot of the current or next frame.
REQ-015 frame_done  out  1  one-cycle pulse at end of frame.
REQ-016 frame_bytes  out  BYTE_CNT_W  bytes written in the last completed frame.
REQ-017 frame_overflow  out  1  last completed frame saw a write while fifo_full.

Function
REQ-018 The scheduler SHALL hold four 3-bit schedule slots; any cfg_data value other than 000, 100 or 111 SHALL be stored as 000.
REQ-019 A cfg_we write SHALL take effect on the next edge, in any state, and SHALL be used at the next schedule lookup.
REQ-020 States: IDLE (wait for vsync low), ARMED (command stable, vsync low), ACTIVE (vsync high, counting), DONE (one-cycle end-of-frame).
REQ-021 IDLE->ARMED on the first edge that samples vsync low; ARMED->ACTIVE on vsync high; ACTIVE->DONE on vsync low; DONE->ARMED if vsync is low, DONE->ACTIVE if vsync is high.
REQ-022 compress_command SHALL change only on the DONE exit edge, so it is stable before every vsync rise that is preceded by at least 2 vsync-low cycles.
REQ-023 In ACTIVE, each cycle with adapter_write_en=1 SHALL increment the byte counter, marker bytes included; the counter SHALL saturate at all-ones.
REQ-024 In ACTIVE, a cycle with adapter_write_en=1 and fifo_full=1 SHALL set the frame overflow flag.
REQ-025 On entry to DONE: frame_done=1, frame_bytes=counter, frame_overflow=flag; the counter and flag SHALL clear on the same edge.
REQ-026 On DONE exit: frame_done=0, and slot_idx SHALL advance by 1, wrapping to 0 past cfg_len; if slot_idx > cfg_len, it SHALL go to 0.
REQ-027 Next mode on DONE exit, base value: schedule[new slot_idx].
REQ-028 Next mode on DONE exit, escalated value: if the hold counter > 0, the mode SHALL be escalated (000->100, 100->111, 111->111) by the stored escalation level (1 or 2).
REQ-029 If cfg_adaptive=1 and the frame overflowed: hold counter = ADAPT_HOLD and escalation level = min(level+1, 2). Otherwise a nonzero hold counter SHALL decrement, and level SHALL clear when it reaches 0.
REQ-030 If vsync rises during DONE, the adapter has latched the old command; the block SHALL still apply the update and count the new frame normally.
REQ-031 cfg_adaptive=0 SHALL clear the hold counter and escalation level at the next DONE exit.

Reset
REQ-032 While reset=0, the block SHALL force: state IDLE, compress_command=000, slot_idx=0, all slots=000, frame_done=0, frame_bytes=0, frame_overflow=0, counter=0, hold=0, level=0.
REQ-033 Reset mid-frame SHALL discard the partial frame; after release, the block SHALL not count until vsync is sampled low and then rises again.

Structure
REQ-034 Shared package cam_pkg: mode constants MODE_RAW=000, MODE_DOWN=100, MODE_DELTA=111; state enumeration; escalate-mode function.
REQ-035 The 4x3 schedule storage with sanitising write SHALL be sub-module sched_regfile; all other logic stays in capture_scheduler.

Verification
REQ-036 Schedule {000,100,111,000}, cfg_len=2, 4 frames -> compress_command 100,111,000,100 after successive DONE exits; slot_idx 1,2,0,1.
REQ-037 Frame of 3 markers + 200 writes -> frame_bytes=203, a single frame_done pulse one edge after vsync falls.
REQ-038 cfg_adaptive=1, schedule all 000, one write with fifo_full in frame 1 -> commands 100 for 4 frames, then 000.
REQ-039 Overflow in two consecutive frames -> second command 111; 2^18+5 writes -> frame_bytes=0x3FFFF.
REQ-040 Reset asserted mid-ACTIVE, released with vsync high -> no frame_done until a later full vsync low/high/low cycle; all outputs at reset values meanwhile.
REQ-041 cfg_data=011 written to slot 0 -> read-back via schedule use is 000; cfg_len reduced to 0 while slot_idx=2 -> next slot_idx=0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture scheduler: compress modes, FSM
// states and the mode-escalation helper.
package cam_pkg;

  localparam logic [2:0] MODE_RAW   = 3'b000;
  localparam logic [2:0] MODE_DOWN  = 3'b100;
  localparam logic [2:0] MODE_DELTA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ACTIVE,
    ST_DONE
  } state_e;

  // Only the three defined modes are ever stored; anything else means raw.
  function automatic logic [2:0] sanitize_mode(input logic [2:0] mode);
    return ((mode == MODE_DOWN) || (mode == MODE_DELTA)) ? mode : MODE_RAW;
  endfunction

  function automatic logic [2:0] step_mode(input logic [2:0] mode);
    return (mode == MODE_RAW) ? MODE_DOWN : MODE_DELTA;
  endfunction

  function automatic logic [2:0] escalate_mode(input logic [2:0] mode,
                                               input logic [1:0] level);
    logic [2:0] res;
    res = mode;
    if (level >= 2'd1) res = step_mode(res);
    if (level >= 2'd2) res = step_mode(res);
    return res;
  endfunction

endpackage

// File: rtl/sched_regfile.sv
// Four-entry schedule of compress modes; writes are sanitised, reads are
// combinational so the lookup sees the slot chosen on the same edge.
module sched_regfile
  import cam_pkg::*;
(
  input  logic       pclk,
  input  logic       reset,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [2:0] wdata_i,
  input  logic [1:0] raddr_i,
  output logic [2:0] rdata_o
);

  logic [2:0] slot_rd [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    logic [2:0] mode_q;

    always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
        mode_q <= MODE_RAW;
      end else if (we_i && (waddr_i == 2'(gi))) begin
        mode_q <= sanitize_mode(wdata_i);
      end
    end

    assign slot_rd[gi] = mode_q;
  end

  assign rdata_o = slot_rd[raddr_i];

endmodule

// File: rtl/capture_scheduler.sv
// Per-frame compress-mode scheduler: tracks camera vsync, counts adapter
// writes per frame and picks the next frame's mode from the schedule.
module capture_scheduler
  import cam_pkg::*;
#(
  parameter int BYTE_CNT_W = 18,
  parameter int ADAPT_HOLD = 4
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  cam_vsync,
  input  logic                  adapter_write_en,
  input  logic                  fifo_full,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [2:0]            cfg_data,
  input  logic [1:0]            cfg_len,
  input  logic                  cfg_adaptive,
  output logic [2:0]            compress_command,
  output logic [1:0]            slot_idx,
  output logic                  frame_done,
  output logic [BYTE_CNT_W-1:0] frame_bytes,
  output logic                  frame_overflow
);

  localparam int HOLD_W = (ADAPT_HOLD < 1) ? 1 : $clog2(ADAPT_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(ADAPT_HOLD);

  state_e                state_q, state_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [1:0]            slot_q, slot_d;
  logic                  done_q, done_d;
  logic [BYTE_CNT_W-1:0] bytes_q, bytes_d;
  logic                  ovf_q, ovf_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  flag_q, flag_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [1:0]            level_q, level_d;

  logic [1:0]            next_slot;
  logic [2:0]            sched_mode;

  // A shortened schedule can leave slot_q beyond cfg_len; that also wraps to 0.
  assign next_slot = (slot_q >= cfg_len) ? 2'd0 : slot_q + 2'd1;

  sched_regfile u_sched (
    .pclk    (pclk),
    .reset   (reset),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .raddr_i (next_slot),
    .rdata_o (sched_mode)
  );

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= MODE_RAW;
      slot_q  <= 2'd0;
      done_q  <= 1'b0;
      bytes_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      hold_q  <= '0;
      level_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
      bytes_q <= bytes_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      hold_q  <= hold_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    slot_d  = slot_q;
    done_d  = 1'b0;
    bytes_d = bytes_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    hold_d  = hold_q;
    level_d = level_q;

    case (state_q)
      ST_IDLE: begin
        if (!cam_vsync) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (cam_vsync) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // The cycle that samples vsync low already belongs to the gap.
        if (!cam_vsync) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          bytes_d = cnt_q;
          ovf_d   = flag_q;
          cnt_d   = '0;
          flag_d  = 1'b0;
        end else if (adapter_write_en) begin
          if (~&cnt_q) cnt_d = cnt_q + BYTE_CNT_W'(1);
          if (fifo_full) flag_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = cam_vsync ? ST_ACTIVE : ST_ARMED;
        slot_d  = next_slot;
        if (!cfg_adaptive) begin
          hold_d  = '0;
          level_d = 2'd0;
        end else if (ovf_q) begin
          hold_d  = HOLD_INIT;
          level_d = (level_q == 2'd2) ? 2'd2 : level_q + 2'd1;
        end else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q == HOLD_W'(1)) level_d = 2'd0;
        end
        cmd_d = (hold_d != '0) ? escalate_mode(sched_mode, level_d) : sched_mode;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign compress_command = cmd_q;
  assign slot_idx         = slot_q;
  assign frame_done       = done_q;
  assign frame_bytes      = bytes_q;
  assign frame_overflow   = ovf_q;

endmodule

// File: tb/tb_capture_scheduler.sv
// Self-checking bench for capture_scheduler: directed scenarios plus random
// frames, checked against a frame-level reference model.
module tb_capture_scheduler;

  localparam int W    = 10;
  localparam int HOLD = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         pclk = 1'b0;
  logic         reset;
  logic         cam_vsync;
  logic         adapter_write_en;
  logic         fifo_full;
  logic         cfg_we;
  logic [1:0]   cfg_addr;
  logic [2:0]   cfg_data;
  logic [1:0]   cfg_len;
  logic         cfg_adaptive;
  logic [2:0]   compress_command;
  logic [1:0]   slot_idx;
  logic         frame_done;
  logic [W-1:0] frame_bytes;
  logic         frame_overflow;

  capture_scheduler #(.BYTE_CNT_W(W), .ADAPT_HOLD(HOLD)) dut (
    .pclk             (pclk),
    .reset            (reset),
    .cam_vsync        (cam_vsync),
    .adapter_write_en (adapter_write_en),
    .fifo_full        (fifo_full),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_data         (cfg_data),
    .cfg_len          (cfg_len),
    .cfg_adaptive     (cfg_adaptive),
    .compress_command (compress_command),
    .slot_idx         (slot_idx),
    .frame_done       (frame_done),
    .frame_bytes      (frame_bytes),
    .frame_overflow   (frame_overflow)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;
  int n_frames = 0;
  bit tb_active = 1'b0;

  // Reference model state
  logic [2:0] m_sched [4];
  int         m_slot;
  int         m_hold;
  int         m_level;
  logic [2:0] m_cmd;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_sanitize(input logic [2:0] d);
    return (d == 3'b100 || d == 3'b111) ? d : 3'b000;
  endfunction

  // Modes form a ladder raw < down < delta; escalation climbs it, capped at the top.
  function automatic logic [2:0] m_escalate(input logic [2:0] m, input int lvl);
    int rank;
    rank = (m == 3'b111) ? 2 : (m == 3'b100) ? 1 : 0;
    rank = rank + lvl;
    if (rank > 2) rank = 2;
    return (rank == 2) ? 3'b111 : (rank == 1) ? 3'b100 : 3'b000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_sched[i] = 3'b000;
    m_slot = 0; m_hold = 0; m_level = 0; m_cmd = 3'b000;
  endtask

  task automatic model_frame_end(input bit ovf);
    m_slot = (m_slot >= int'(cfg_len)) ? 0 : m_slot + 1;
    if (!cfg_adaptive) begin
      m_hold = 0; m_level = 0;
    end else if (ovf) begin
      m_hold = HOLD;
      m_level = (m_level + 1 > 2) ? 2 : m_level + 1;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_level = 0;
    end
    m_cmd = (m_hold > 0) ? m_escalate(m_sched[m_slot], m_level) : m_sched[m_slot];
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [2:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
    m_sched[addr] = m_sanitize(data);
  endtask

  // One complete frame: vsync gap (unless already active), nw writes, vsync fall,
  // DONE; optionally vsync rises again while in DONE.
  task automatic run_frame(input int nw, input bit ovf, input int low, input bit rise_in_done);
    int ov_pos;
    int exp_bytes;
    if (!tb_active) begin
      cam_vsync = 1'b0;
      repeat (low) tick();
      cam_vsync = 1'b1;
      tick();
    end
    ov_pos = (ovf && nw > 0) ? $urandom_range(0, nw - 1) : -1;
    for (int i = 0; i < nw; i++) begin
      if (nw < 100 && $urandom_range(0, 7) == 0) begin
        adapter_write_en = 1'b0; fifo_full = 1'b1;
        tick();
      end
      adapter_write_en = 1'b1;
      fifo_full = (i == ov_pos);
      tick();
    end
    adapter_write_en = 1'b0; fifo_full = 1'b0; cam_vsync = 1'b0;
    chk("done_before_fall", frame_done, 0);
    tick();
    exp_bytes = (nw > MAXV) ? MAXV : nw;
    chk("done_pulse", frame_done, 1);
    chk("frame_bytes", frame_bytes, exp_bytes);
    chk("frame_overflow", frame_overflow, (ov_pos >= 0));
    model_frame_end(ov_pos >= 0);
    if (rise_in_done) cam_vsync = 1'b1;
    tick();
    chk("done_cleared", frame_done, 0);
    chk("slot_idx", slot_idx, m_slot);
    chk("compress_command", compress_command, m_cmd);
    tb_active = rise_in_done;
    n_frames++;
    $display("frame %0d: writes=%0d bytes=%0d ovf=%0b slot=%0d cmd=%03b",
             n_frames, nw, exp_bytes, (ov_pos >= 0), m_slot, m_cmd);
  endtask

  initial begin
    reset = 1'b0; cam_vsync = 1'b0; adapter_write_en = 1'b0; fifo_full = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 3'd0; cfg_len = 2'd3; cfg_adaptive = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_cmd", compress_command, 0);
    chk("rst_slot", slot_idx, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_bytes", frame_bytes, 0);
    chk("rst_ovf", frame_overflow, 0);
    reset = 1'b1;
    tick();

    // Schedule {000,100,111,000}, length 3 -> 100,111,000,100
    cfg_write(2'd0, 3'b000); cfg_write(2'd1, 3'b100);
    cfg_write(2'd2, 3'b111); cfg_write(2'd3, 3'b000);
    cfg_len = 2'd2;
    for (int f = 0; f < 4; f++) run_frame(5 + f, 1'b0, 3, 1'b0);

    // Markers plus pixels are all counted
    run_frame(203, 1'b0, 2, 1'b0);

    // Single overflow holds the escalated mode for HOLD frames
    for (int i = 0; i < 4; i++) cfg_write(2'(i), 3'b000);
    cfg_adaptive = 1'b1;
    run_frame(10, 1'b1, 2, 1'b0);
    for (int f = 0; f < 5; f++) run_frame(4, 1'b0, 2, 1'b0);

    // Back-to-back overflows climb two levels; then counter saturation
    run_frame(6, 1'b1, 2, 1'b0);
    run_frame(6, 1'b1, 2, 1'b0);
    run_frame(MAXV + 6, 1'b0, 2, 1'b0);
    cfg_adaptive = 1'b0;
    run_frame(3, 1'b0, 2, 1'b0);

    // Illegal mode sanitised; shrinking the schedule below the current slot
    cfg_write(2'd0, 3'b011);
    cfg_write(2'd1, 3'b111);
    cfg_len = 2'd3;
    for (int k = 0; k < 8 && m_slot != 2; k++) run_frame(2, 1'b0, 2, 1'b0);
    chk("slot_reached_2", slot_idx, 2);
    cfg_len = 2'd0;
    run_frame(2, 1'b0, 2, 1'b0);
    run_frame(2, 1'b0, 2, 1'b0);

    // vsync rising while in DONE
    cfg_len = 2'd3;
    run_frame(7, 1'b0, 2, 1'b1);
    run_frame(9, 1'b0, 2, 1'b1);
    run_frame(4, 1'b0, 2, 1'b0);

    // Randomised frames
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) cfg_write(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 5) == 0) cfg_len = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) cfg_adaptive = ~cfg_adaptive;
      run_frame($urandom_range(0, 40), ($urandom_range(0, 3) == 0), $urandom_range(2, 4),
                (f < 29) && ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of an active frame, released with vsync high
    if (!tb_active) begin
      cam_vsync = 1'b0; repeat (3) tick();
      cam_vsync = 1'b1; tick();
    end
    adapter_write_en = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    chk("midrst_cmd", compress_command, 0);
    chk("midrst_slot", slot_idx, 0);
    chk("midrst_bytes", frame_bytes, 0);
    chk("midrst_ovf", frame_overflow, 0);
    tick();
    reset = 1'b1;
    model_reset();
    tb_active = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("postrst_done", frame_done, 0);
      chk("postrst_bytes", frame_bytes, 0);
    end
    adapter_write_en = 1'b0; cam_vsync = 1'b0;
    tick();
    chk("postrst_fall_done", frame_done, 0);
    run_frame(7, 1'b0, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
